// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl: multi-cycle control and register stage for a Hack-style CPU.
// Fetches instructions over a valid/ready handshake. Holds the A, D and PC
// registers. Sequences data-memory reads and writes over a req/ack handshake.
// Drives an external combinational 16-bit ALU and commits its results and
// jumps.
//
// Ports
//   clk, rst_n                        clock, asynchronous active-low reset
//   pc[14:0]                          instruction address (registered PC)
//   instr[15:0], instr_valid          instruction word and its valid
//   instr_ready                       instruction accepted this cycle (FETCH only)
//   mem_req, mem_we                   data-memory request, 1 = write
//   mem_addr[14:0], mem_wdata[15:0]   data address and write data
//   mem_rdata[15:0], mem_ack          read data, request completion
//   alu_x, alu_y[15:0], alu_op[5:0]   ALU operands and op code
//   alu_out[15:0], alu_zr, alu_ng     ALU result and flags
//   retired                           one-cycle pulse in the commit cycle
module hack_cpu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  output logic [14:0] pc,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_op,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic        retired
);

  typedef enum logic [1:0] {S_FETCH, S_MEMRD, S_EXEC, S_MEMWR} state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, d_q, m_q, r_q;
  logic [14:0] pc_q;
  // Only the a, op, d and j fields of a C-instruction are ever consulted,
  // so the unused top bits of IR are not stored.
  logic [12:0] ir_q;
  logic        jmp_q;
  logic [15:0] x_hold, y_hold;
  logic [5:0]  op_hold;

  logic        unused_bits;
  assign unused_bits = ^instr[14:13];

  logic        ir_a, ir_da, ir_dd, ir_dm;
  logic [15:0] exec_y;
  logic        exec_jmp;
  assign ir_a  = ir_q[12];
  assign ir_da = ir_q[5];
  assign ir_dd = ir_q[4];
  assign ir_dm = ir_q[3];
  assign exec_y = ir_a ? m_q : a_q;
  assign exec_jmp = (ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) |
                    (ir_q[0] & ~alu_ng & ~alu_zr);

  logic        ld_ainstr, ld_ir, ld_m, ld_r, ld_jmp, commit, commit_jmp;
  logic [15:0] commit_res;

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ld_ainstr   = 1'b0;
    ld_ir       = 1'b0;
    ld_m        = 1'b0;
    ld_r        = 1'b0;
    ld_jmp      = 1'b0;
    commit      = 1'b0;
    commit_jmp  = 1'b0;
    commit_res  = alu_out;
    case (state_q)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (!instr[15]) begin
            ld_ainstr = 1'b1;
          end else begin
            ld_ir   = 1'b1;
            state_d = instr[12] ? S_MEMRD : S_EXEC;
          end
        end
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ld_m    = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        ld_r = 1'b1;
        if (ir_dm) begin
          // The jump decision must survive until the write completes.
          ld_jmp  = 1'b1;
          state_d = S_MEMWR;
        end else begin
          commit     = 1'b1;
          commit_jmp = exec_jmp;
          state_d    = S_FETCH;
        end
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          commit     = 1'b1;
          commit_res = r_q;
          commit_jmp = jmp_q;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      a_q     <= '0;
      d_q     <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      m_q     <= '0;
      r_q     <= '0;
      jmp_q   <= 1'b0;
      x_hold  <= '0;
      y_hold  <= '0;
      op_hold <= '0;
    end else begin
      state_q <= state_d;
      if (ld_ainstr) begin
        a_q  <= instr;
        pc_q <= pc_q + 15'd1;
      end
      if (ld_ir)  ir_q  <= instr[12:0];
      if (ld_m)   m_q   <= mem_rdata;
      if (ld_r)   r_q   <= alu_out;
      if (ld_jmp) jmp_q <= exec_jmp;
      if (state_q == S_EXEC) begin
        x_hold  <= d_q;
        y_hold  <= exec_y;
        op_hold <= ir_q[11:6];
      end
      // Jump target uses A as it was before this instruction's own update.
      if (commit) begin
        if (ir_da) a_q <= commit_res;
        if (ir_dd) d_q <= commit_res;
        pc_q <= commit_jmp ? a_q[14:0] : pc_q + 15'd1;
      end
    end
  end

  // Outside EXEC the ALU inputs freeze at their EXEC values to avoid toggling.
  assign alu_x  = (state_q == S_EXEC) ? d_q        : x_hold;
  assign alu_y  = (state_q == S_EXEC) ? exec_y     : y_hold;
  assign alu_op = (state_q == S_EXEC) ? ir_q[11:6] : op_hold;

  // A stays constant through MEMRD/MEMWR, so address and data are stable.
  assign mem_addr  = a_q[14:0];
  assign mem_wdata = r_q;
  assign pc        = pc_q;
  assign retired   = rst_n & (commit | ld_ainstr);

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
module tb_hack_cpu_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] pc;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        mem_req, mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] alu_x, alu_y, alu_out;
  logic [5:0]  alu_op;
  logic        alu_zr, alu_ng, retired;

  always #5 clk = ~clk;

  hack_cpu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng), .retired(retired)
  );

  // Hack ALU: op = zx nx zy ny f no
  function automatic logic [15:0] alu_f(input logic [15:0] x, input logic [15:0] y,
                                        input logic [5:0] op);
    logic [15:0] xx, yy, o;
    xx = op[5] ? 16'h0 : x;
    if (op[4]) xx = ~xx;
    yy = op[3] ? 16'h0 : y;
    if (op[2]) yy = ~yy;
    o = op[1] ? xx + yy : xx & yy;
    if (op[0]) o = ~o;
    return o;
  endfunction

  assign alu_out = alu_f(alu_x, alu_y, alu_op);
  assign alu_zr  = (alu_out == 16'h0);
  assign alu_ng  = alu_out[15];

  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] ins;
    logic        ack;
    logic [15:0] rd;
    logic        e_ready, e_req, e_we, e_ret, chk_alu;
    logic [14:0] e_pc, e_addr;
    logic [15:0] e_wdata, e_x, e_y;
    logic [5:0]  e_op;
  } cyc_t;

  cyc_t        q[$];
  logic [15:0] mA, mD;
  logic [14:0] mPC;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic cyc_t base(input logic busy);
    cyc_t c;
    c.rst = 1'b0;
    c.iv = busy ? ($urandom_range(0, 1) == 1) : 1'b0;
    c.ins = 16'($urandom);
    c.ack = ($urandom_range(0, 1) == 1);
    c.rd = 16'($urandom);
    c.e_ready = !busy;
    c.e_req = 1'b0;
    c.e_we = 1'b0;
    c.e_ret = 1'b0;
    c.chk_alu = 1'b0;
    c.e_pc = mPC;
    c.e_addr = '0;
    c.e_wdata = '0;
    c.e_x = '0;
    c.e_y = '0;
    c.e_op = '0;
    return c;
  endfunction

  // Builds the per-cycle expectation for one instruction from the
  // architectural rules and advances the model state. abort >= 0 applies a
  // reset in that write wait cycle instead of completing the instruction.
  task automatic push_instr(input logic [15:0] ins, input logic [15:0] rdv,
                            input int rw, input int ww, input int abort);
    cyc_t c;
    logic [15:0] y, res;
    logic jmp;
    c = base(1'b0);
    c.iv = 1'b1;
    c.ins = ins;
    if (!ins[15]) begin
      c.e_ret = 1'b1;
      q.push_back(c);
      mA = ins;
      mPC = mPC + 15'd1;
      return;
    end
    q.push_back(c);
    if (ins[12]) begin
      for (int i = 0; i <= rw; i++) begin
        c = base(1'b1);
        c.e_req = 1'b1;
        c.e_addr = mA[14:0];
        c.ack = (i == rw);
        if (i == rw) c.rd = rdv;
        q.push_back(c);
      end
    end
    y = ins[12] ? rdv : mA;
    res = alu_f(mD, y, ins[11:6]);
    jmp = (ins[2] && res[15]) || (ins[1] && res == 16'h0) ||
          (ins[0] && !res[15] && res != 16'h0);
    c = base(1'b1);
    c.chk_alu = 1'b1;
    c.e_x = mD;
    c.e_y = y;
    c.e_op = ins[11:6];
    c.e_ret = !ins[3];
    q.push_back(c);
    if (ins[3]) begin
      for (int i = 0; i <= ww; i++) begin
        c = base(1'b1);
        if (abort >= 0 && i == abort) begin
          c.rst = 1'b1;
          c.iv = 1'b0;
          c.ack = 1'b1;
          c.e_ready = 1'b1;
          c.e_pc = '0;
          q.push_back(c);
          mA = '0;
          mD = '0;
          mPC = '0;
          c = base(1'b0);
          c.ack = 1'b1;
          q.push_back(c);
          return;
        end
        c.e_req = 1'b1;
        c.e_we = 1'b1;
        c.e_addr = mA[14:0];
        c.e_wdata = res;
        c.ack = (i == ww);
        c.e_ret = (i == ww);
        q.push_back(c);
      end
    end
    mPC = jmp ? mA[14:0] : mPC + 15'd1;
    if (ins[5]) mA = res;
    if (ins[4]) mD = res;
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) q.push_back(base(1'b0));
  endtask

  initial begin
    cyc_t e;
    logic [15:0] r;
    mA = '0;
    mD = '0;
    mPC = '0;

    // @5 ; D=A
    push_instr(16'h0005, 16'h0, 0, 0, -1);
    push_instr(16'hEC10, 16'h0, 0, 0, -1);
    chk("pin_D_eq_5", 32'(mD), 32'd5);
    chk("pin_PC_eq_2", 32'(mPC), 32'd2);
    // @7 ; D=A ; @100 ; M=D+1 with three ack wait cycles
    push_instr(16'h0007, 16'h0, 0, 0, -1);
    push_instr(16'hEC10, 16'h0, 0, 0, -1);
    push_instr(16'd100, 16'h0, 0, 0, -1);
    push_instr(16'hE7C8, 16'h0, 0, 3, -1);
    chk("pin_wr_addr_100", 32'(q[q.size()-1].e_addr), 32'd100);
    chk("pin_wr_data_8", 32'(q[q.size()-1].e_wdata), 32'd8);
    // @20 ; AD=M reading 0x1234 ; M=D goes to 0x1234
    push_instr(16'd20, 16'h0, 0, 0, -1);
    push_instr(16'hFC30, 16'h1234, 1, 0, -1);
    push_instr(16'hE308, 16'h0, 0, 0, -1);
    chk("pin_wr_addr_1234", 32'(q[q.size()-1].e_addr), 32'h1234);
    // D=-1 ; @9 ; D;JLT ; @9 ; D;JGT ; @9 ; 0;JMP
    push_instr(16'hEE90, 16'h0, 0, 0, -1);
    push_instr(16'd9, 16'h0, 0, 0, -1);
    push_instr(16'hE304, 16'h0, 0, 0, -1);
    chk("pin_jlt_pc9", 32'(mPC), 32'd9);
    push_instr(16'd9, 16'h0, 0, 0, -1);
    push_instr(16'hE301, 16'h0, 0, 0, -1);
    chk("pin_jgt_pc11", 32'(mPC), 32'd11);
    push_instr(16'd9, 16'h0, 0, 0, -1);
    push_instr(16'hEA87, 16'h0, 0, 0, -1);
    chk("pin_jmp_pc9", 32'(mPC), 32'd9);
    // @30 ; AM=M-1 with M=5
    push_instr(16'd30, 16'h0, 0, 0, -1);
    push_instr(16'hFCA8, 16'd5, 0, 1, -1);
    chk("pin_am_data_4", 32'(q[q.size()-1].e_wdata), 32'd4);
    chk("pin_am_A_4", 32'(mA), 32'd4);
    // PC wrap: jump to 0x7FFF then an A-instruction
    push_instr(16'h7FFF, 16'h0, 0, 0, -1);
    push_instr(16'hEA87, 16'h0, 0, 0, -1);
    push_instr(16'h0003, 16'h0, 0, 0, -1);
    chk("pin_pc_wrap", 32'(mPC), 32'd0);
    // reset during MEMWR, then M=D must write 0 to address 0
    push_instr(16'd100, 16'h0, 0, 0, -1);
    push_instr(16'hE308, 16'h0, 0, 5, 2);
    push_instr(16'hE308, 16'h0, 0, 0, -1);
    chk("pin_post_rst_addr", 32'(q[q.size()-1].e_addr), 32'd0);
    // randomized instruction stream
    for (int n = 0; n < 250; n++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 1) == 1) push_instr({1'b0, r[14:0]}, 16'h0, 0, 0, -1);
      else push_instr({3'b111, r[12:0]}, 16'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
      if ($urandom_range(0, 3) == 0) push_idle(int'($urandom_range(1, 2)));
    end

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);

    // cycle-by-cycle drive and compare
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      rst_n = !e.rst;
      instr_valid = e.iv;
      instr = e.ins;
      mem_ack = e.ack;
      mem_rdata = e.rd;
      #1;
      chk("instr_ready", 32'(instr_ready), 32'(e.e_ready));
      chk("mem_req", 32'(mem_req), 32'(e.e_req));
      chk("retired", 32'(retired), 32'(e.e_ret));
      chk("pc", 32'(pc), 32'(e.e_pc));
      if (e.e_req) begin
        chk("mem_we", 32'(mem_we), 32'(e.e_we));
        chk("mem_addr", 32'(mem_addr), 32'(e.e_addr));
        if (e.e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e.e_wdata));
      end
      if (e.chk_alu) begin
        chk("alu_x", 32'(alu_x), 32'(e.e_x));
        chk("alu_y", 32'(alu_y), 32'(e.e_y));
        chk("alu_op", 32'(alu_op), 32'(e.e_op));
      end
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
